// File: rtl/atm_ledger_arbiter_if.sv
// atm_ledger_arbiter_if: terminal request/response and ledger-load bundle
interface atm_ledger_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ACCT_DEPTH = 4,
  parameter int W = 12
);
  localparam int IW = ACCT_DEPTH > 1 ? $clog2(ACCT_DEPTH) : 1;
  logic [NUM_PORTS-1:0] req;
  logic [3*NUM_PORTS-1:0] op;
  logic [W*NUM_PORTS-1:0] src_acct;
  logic [W*NUM_PORTS-1:0] dst_acct;
  logic [W*NUM_PORTS-1:0] amount;
  logic init_we;
  logic [IW-1:0] init_idx;
  logic [W-1:0] init_acct;
  logic [W-1:0] init_bal;
  logic [NUM_PORTS-1:0] gnt;
  logic [NUM_PORTS-1:0] done;
  logic [2:0] status;
  logic [W-1:0] bal_out;
  logic [W-1:0] dst_bal_out;
  logic busy;
  modport master (
    output req, op, src_acct, dst_acct, amount, init_we, init_idx, init_acct, init_bal,
    input gnt, done, status, bal_out, dst_bal_out, busy
  );
  modport slave (
    input req, op, src_acct, dst_acct, amount, init_we, init_idx, init_acct, init_bal,
    output gnt, done, status, bal_out, dst_bal_out, busy
  );
endinterface

// File: rtl/atm_ledger_arbiter.sv
// atm_ledger_arbiter: round-robin arbiter running atomic ATM transactions on an owned ledger
module atm_ledger_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ACCT_DEPTH = 4,
  parameter int W = 12
) (
  input logic clk,
  input logic rst,
  atm_ledger_arbiter_if.slave b
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int IW = ACCT_DEPTH > 1 ? $clog2(ACCT_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, LOOKUP, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic vld [ACCT_DEPTH];
  logic [W-1:0] acct [ACCT_DEPTH];
  logic [W-1:0] bal [ACCT_DEPTH];
  logic [PW-1:0] rr_ptr, win_c;
  logic [PW:0] j;
  logic any, grant;
  logic [2:0] l_op, op_c, st_c;
  logic [W-1:0] l_src, l_dst, l_amt, src_c, dst_c, amt_c, sb, db, nsb;
  logic [IW-1:0] src_idx, dst_idx, s_i, d_i;
  logic src_f, dst_f, s_f, d_f, is_x, ok;
  logic [W:0] s_sum, d_sum;

  // Descending scan so the requester closest after rr_ptr wins
  always_comb begin
    any = 1'b0;
    win_c = '0;
    j = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      j = {1'b0, rr_ptr} + (PW+1)'(k);
      j = j >= (PW+1)'(NUM_PORTS) ? j - (PW+1)'(NUM_PORTS) : j;
      if (b.req[j[PW-1:0]]) begin
        any = 1'b1;
        win_c = j[PW-1:0];
      end
    end
    op_c = '0;
    src_c = '0;
    dst_c = '0;
    amt_c = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (win_c == PW'(p)) begin
        op_c = b.op[3*p +: 3];
        src_c = b.src_acct[W*p +: W];
        dst_c = b.dst_acct[W*p +: W];
        amt_c = b.amount[W*p +: W];
      end
  end

  assign grant = state == IDLE && any && !b.init_we;
  assign b.busy = state != IDLE;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  always_comb
    state_nx = state == IDLE ? (grant ? LOOKUP : IDLE) :
               state == LOOKUP ? EXEC :
               state == EXEC ? RESP : IDLE;

  // Descending scan so the lowest matching index wins
  always_comb begin
    s_f = 1'b0;
    s_i = '0;
    d_f = 1'b0;
    d_i = '0;
    for (int i = ACCT_DEPTH - 1; i >= 0; i--) begin
      if (vld[i] && acct[i] == l_src) begin
        s_f = 1'b1;
        s_i = IW'(i);
      end
      if (vld[i] && acct[i] == l_dst) begin
        d_f = 1'b1;
        d_i = IW'(i);
      end
    end
  end

  always_comb begin
    sb = src_f ? bal[src_idx] : '0;
    db = dst_f ? bal[dst_idx] : '0;
    is_x = l_op == 3'd3;
    s_sum = {1'b0, sb} + {1'b0, l_amt};
    d_sum = {1'b0, db} + {1'b0, l_amt};
    st_c = (l_op > 3'd3 || (is_x && l_src == l_dst)) ? 3'd4 :
           !src_f ? 3'd1 :
           (is_x && !dst_f) ? 3'd2 :
           (l_op != 3'd2 && l_amt == '0) ? 3'd5 :
           ((l_op == 3'd1 || is_x) && l_amt > sb) ? 3'd3 :
           ((l_op == 3'd0 && s_sum[W]) || (is_x && d_sum[W])) ? 3'd6 : 3'd0;
    ok = st_c == 3'd0;
    nsb = l_op == 3'd0 ? s_sum[W-1:0] : (l_op == 3'd1 || is_x) ? sb - l_amt : sb;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr_ptr <= '0;
      l_op <= '0;
      l_src <= '0;
      l_dst <= '0;
      l_amt <= '0;
      src_idx <= '0;
      dst_idx <= '0;
      src_f <= 1'b0;
      dst_f <= 1'b0;
      b.gnt <= '0;
      b.done <= '0;
      b.status <= '0;
      b.bal_out <= '0;
      b.dst_bal_out <= '0;
      for (int i = 0; i < ACCT_DEPTH; i++) begin
        vld[i] <= 1'b0;
        acct[i] <= '0;
        bal[i] <= '0;
      end
    end else begin
      b.done <= '0;
      if (state == IDLE && b.init_we) begin
        vld[b.init_idx] <= 1'b1;
        acct[b.init_idx] <= b.init_acct;
        bal[b.init_idx] <= b.init_bal;
      end
      if (grant) begin
        l_op <= op_c;
        l_src <= src_c;
        l_dst <= dst_c;
        l_amt <= amt_c;
        b.gnt <= NUM_PORTS'(1) << win_c;
        rr_ptr <= win_c == PW'(NUM_PORTS - 1) ? '0 : win_c + 1'b1;
      end
      if (state == LOOKUP) begin
        src_idx <= s_i;
        dst_idx <= d_i;
        src_f <= s_f;
        dst_f <= d_f;
      end
      if (state == EXEC) begin
        b.done <= b.gnt;
        b.status <= st_c;
        b.bal_out <= ok ? nsb : sb;
        b.dst_bal_out <= is_x ? (ok ? d_sum[W-1:0] : db) : '0;
        if (ok && l_op != 3'd2) bal[src_idx] <= nsb;
        if (ok && is_x) bal[dst_idx] <= d_sum[W-1:0];
      end
      if (state == RESP) b.gnt <= '0;
    end
endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// tb_atm_ledger_arbiter: directed and random transactions checked against a ledger model
module tb_atm_ledger_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int m_vld [4];
  int m_acct [4];
  int m_bal [4];
  int m_rr = 0;
  int f_op [2];
  int f_src [2];
  int f_dst [2];
  int f_amt [2];
  int last_st, last_bo, last_dbo, last_win;
  int accts [5] = '{'h101, 'h202, 'h303, 'h404, 'h999};

  atm_ledger_arbiter_if #(.NUM_PORTS(2), .ACCT_DEPTH(4), .W(12)) bus ();
  atm_ledger_arbiter #(.NUM_PORTS(2), .ACCT_DEPTH(4), .W(12)) dut (.clk(clk), .rst(rst), .b(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int find(input int a);
    for (int i = 0; i < 4; i++) if (m_vld[i] != 0 && m_acct[i] == a) return i;
    return -1;
  endfunction

  // Reference semantics: ordered checks, then apply the update to the model ledger
  task automatic model_exec(input int o, input int s, input int d, input int a,
                            output int st, output int bo, output int dbo);
    int si, di, sb, db;
    si = find(s);
    di = find(d);
    sb = si >= 0 ? m_bal[si] : 0;
    db = di >= 0 ? m_bal[di] : 0;
    if (o > 3 || (o == 3 && s == d)) st = 4;
    else if (si < 0) st = 1;
    else if (o == 3 && di < 0) st = 2;
    else if (o != 2 && a == 0) st = 5;
    else if ((o == 1 || o == 3) && a > sb) st = 3;
    else if ((o == 0 && sb + a > 4095) || (o == 3 && db + a > 4095)) st = 6;
    else st = 0;
    if (st == 0) begin
      if (o == 0) m_bal[si] += a;
      if (o == 1 || o == 3) m_bal[si] -= a;
      if (o == 3) m_bal[di] += a;
    end
    bo = si >= 0 ? m_bal[si] : 0;
    dbo = (o == 3 && di >= 0) ? m_bal[di] : 0;
  endtask

  task automatic load(input int idx, input int a, input int bl);
    bus.init_we = 1'b1;
    bus.init_idx = 2'(idx);
    bus.init_acct = 12'(a);
    bus.init_bal = 12'(bl);
    @(negedge clk);
    bus.init_we = 1'b0;
    m_vld[idx] = 1;
    m_acct[idx] = a;
    m_bal[idx] = bl;
  endtask

  task automatic raise(input int p, input int o, input int s, input int d, input int a);
    f_op[p] = o;
    f_src[p] = s;
    f_dst[p] = d;
    f_amt[p] = a;
    bus.op[3*p +: 3] = 3'(o);
    bus.src_acct[12*p +: 12] = 12'(s);
    bus.dst_acct[12*p +: 12] = 12'(d);
    bus.amount[12*p +: 12] = 12'(a);
    bus.req[p] = 1'b1;
  endtask

  task automatic serve(input bit poke);
    int ew, n, st, bo, dbo;
    ew = -1;
    for (int k = 0; k < 2; k++) if (ew < 0 && bus.req[(m_rr + k) % 2]) ew = (m_rr + k) % 2;
    if (ew < 0) return;
    n = 0;
    while (bus.gnt == 0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (bus.gnt == 0) begin
      check("gnt_timeout", 32'(bus.gnt), 32'(1 << ew));
      bus.req = '0;
      return;
    end
    last_win = ew;
    check("gnt", 32'(bus.gnt), 32'(1 << ew));
    check("busy", 32'(bus.busy), 1);
    m_rr = (ew + 1) % 2;
    model_exec(f_op[ew], f_src[ew], f_dst[ew], f_amt[ew], st, bo, dbo);
    if (poke) begin
      bus.init_we = 1'b1;
      bus.init_idx = 2'd3;
      bus.init_acct = 12'h404;
      bus.init_bal = 12'd77;
    end
    @(negedge clk);
    bus.init_we = 1'b0;
    check("done_early", 32'(bus.done), 0);
    @(negedge clk);
    check("done", 32'(bus.done), 32'(1 << ew));
    check("gnt_hold", 32'(bus.gnt), 32'(1 << ew));
    check("status", 32'(bus.status), 32'(st));
    check("bal_out", 32'(bus.bal_out), 32'(bo));
    check("dst_bal_out", 32'(bus.dst_bal_out), 32'(dbo));
    last_st = int'(bus.status);
    last_bo = int'(bus.bal_out);
    last_dbo = int'(bus.dst_bal_out);
    @(posedge clk);
    #1 bus.req[ew] = 1'b0;
    @(negedge clk);
    check("done_clr", 32'(bus.done), 0);
    check("gnt_clr", 32'(bus.gnt), 0);
    check("idle", 32'(bus.busy), 0);
  endtask

  initial begin
    int n, o, a, r;
    bus.req = '0;
    bus.op = '0;
    bus.src_acct = '0;
    bus.dst_acct = '0;
    bus.amount = '0;
    bus.init_we = 1'b0;
    bus.init_idx = '0;
    bus.init_acct = '0;
    bus.init_bal = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_status", 32'(bus.status), 0);
    check("rst_bal", 32'(bus.bal_out), 0);
    check("rst_dbal", 32'(bus.dst_bal_out), 0);
    check("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    @(negedge clk);
    load(0, 'h101, 500);
    load(1, 'h202, 100);
    load(2, 'h303, 4090);
    raise(0, 1, 'h101, 0, 200);
    serve(0);
    check("wd_status", last_st, 0);
    check("wd_bal", last_bo, 300);
    raise(1, 2, 'h202, 0, 0);
    serve(0);
    check("q_bal", last_bo, 100);
    for (int rep = 0; rep < 2; rep++) begin
      raise(0, 2, 'h101, 0, 0);
      raise(1, 2, 'h202, 0, 0);
      serve(0);
      check("rr_first", last_win, 0);
      serve(0);
      check("rr_second", last_win, 1);
    end
    raise(1, 3, 'h202, 'h101, 150);
    serve(0);
    check("xfer_insuf", last_st, 3);
    check("xfer_insuf_src", last_bo, 100);
    check("xfer_insuf_dst", last_dbo, 300);
    raise(1, 3, 'h202, 'h101, 50);
    serve(0);
    check("xfer_ok", last_st, 0);
    check("xfer_src", last_bo, 50);
    check("xfer_dst", last_dbo, 350);
    raise(0, 0, 'h303, 0, 10);
    serve(0);
    check("dep_ovf", last_st, 6);
    check("dep_ovf_bal", last_bo, 4090);
    raise(0, 0, 'h303, 0, 5);
    serve(0);
    check("dep_max", last_st, 0);
    check("dep_max_bal", last_bo, 4095);
    raise(0, 1, 'h999, 0, 10);
    serve(0);
    check("no_src", last_st, 1);
    raise(1, 3, 'h101, 'h101, 5);
    serve(0);
    check("self_xfer", last_st, 4);
    raise(0, 1, 'h101, 0, 0);
    serve(0);
    check("zero_amt", last_st, 5);
    raise(1, 7, 'h101, 'h202, 5);
    serve(0);
    check("bad_op", last_st, 4);
    raise(0, 1, 'h101, 0, 100);
    n = 0;
    while (bus.gnt == 0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("rst_gnt_seen", 32'(bus.gnt), 1);
    rst = 1'b1;
    bus.req = '0;
    for (int i = 0; i < 4; i++) begin
      m_vld[i] = 0;
      m_acct[i] = 0;
      m_bal[i] = 0;
    end
    m_rr = 0;
    @(negedge clk);
    check("abort_gnt", 32'(bus.gnt), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_status", 32'(bus.status), 0);
    check("abort_bal", 32'(bus.bal_out), 0);
    check("abort_dbal", 32'(bus.dst_bal_out), 0);
    check("abort_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_no_done", 32'(bus.done), 0);
    raise(0, 2, 'h101, 0, 0);
    serve(0);
    check("cleared_ledger", last_st, 1);
    load(0, 'h101, 500);
    load(1, 'h202, 100);
    load(2, 'h303, 4090);
    raise(0, 2, 'h101, 0, 0);
    serve(1);
    check("reload_bal", last_bo, 500);
    raise(0, 2, 'h404, 0, 0);
    serve(0);
    check("busy_init_ignored", last_st, 1);
    load(3, 'h404, 1000);
    for (int it = 0; it < 80; it++) begin
      for (int p = 0; p < 2; p++)
        if (!bus.req[p] && $urandom_range(0, 2) != 0) begin
          o = $urandom_range(0, 9) == 0 ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
          r = $urandom_range(0, 9);
          a = r == 0 ? 0 : r == 1 ? int'($urandom_range(3000, 4095)) : int'($urandom_range(1, 400));
          raise(p, o, accts[$urandom_range(0, 4)], accts[$urandom_range(0, 4)], a);
        end
      if (bus.req == 0) raise($urandom_range(0, 1), 2, accts[$urandom_range(0, 4)], 0, 0);
      serve(0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
